// File: rtl/prog_delay_line.sv
// rtl/prog_delay_line.sv - programmable-length sample delay line with stall, flush and run-time delay reload
module prog_delay_line #(
    parameter int WIDTH     = 10,
    parameter int MAX_DELAY = 8,
    parameter int DELAY     = 4,
    localparam int CW       = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             delay_load,
    input  logic [CW-1:0]    delay_sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    cur_delay,
    output logic [CW-1:0]    count,
    output logic             load_ack
);

    logic [MAX_DELAY:1] vld;
    logic [WIDTH-1:0]   dat [1:MAX_DELAY];
    logic               load_accept;
    logic [CW-1:0]      sel_clamped;
    logic               tap_valid;
    logic [WIDTH-1:0]   tap_data;

    // A reload is only safe when nothing observable is in flight or is about to enter.
    assign load_accept = delay_load &&
                         (flush || ((count == '0) && !(en && in_valid)));

    always_comb begin
        sel_clamped = delay_sel;
        if (delay_sel == '0) begin
            sel_clamped = CW'(1);
        end else if (delay_sel > CW'(MAX_DELAY)) begin
            sel_clamped = CW'(MAX_DELAY);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else if (flush || load_accept) begin
            vld <= '0;
        end else if (en) begin
            vld[1] <= in_valid;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                vld[k] <= vld[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= MAX_DELAY; k++) begin
                dat[k] <= '0;
            end
        end else if (en && !flush) begin
            dat[1] <= in_data;
            for (int k = 2; k <= MAX_DELAY; k++) begin
                dat[k] <= dat[k-1];
            end
        end
    end

    // Output tap selected by the active delay; stages past it are never observed.
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (CW'(k) == cur_delay) begin
                tap_valid = vld[k];
                tap_data  = dat[k];
            end
        end
    end

    assign out_valid = tap_valid;
    assign out_data  = tap_valid ? tap_data : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush || load_accept) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(in_valid) - CW'(out_valid);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_delay <= CW'(DELAY);
            load_ack  <= 1'b0;
        end else begin
            load_ack <= load_accept;
            if (load_accept) begin
                cur_delay <= sel_clamped;
            end
        end
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// tb/tb_prog_delay_line.sv - self-checking bench: vector table, corner sequences, randomized run against a queue model
module tb_prog_delay_line;

    localparam int W    = 10;
    localparam int MAXD = 8;
    localparam int DEF  = 4;
    localparam int CW   = $clog2(MAXD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          delay_load = 1'b0;
    logic [CW-1:0] delay_sel = '0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] cur_delay;
    logic [CW-1:0] count;
    logic          load_ack;

    int checks = 0;
    int failures = 0;

    prog_delay_line #(.WIDTH(W), .MAX_DELAY(MAXD), .DELAY(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .delay_load (delay_load),
        .delay_sel  (delay_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .cur_delay  (cur_delay),
        .count      (count),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    // Reference: list of in-flight samples, each tagged with the number of enabled edges it has seen.
    typedef struct {
        logic [W-1:0] d;
        int           age;
    } smp_t;

    smp_t q[$];
    int   m_cur = DEF;
    bit   m_ack = 1'b0;

    function automatic int m_count();
        int n = 0;
        foreach (q[i]) if (q[i].age <= m_cur) n++;
        return n;
    endfunction

    function automatic bit m_ov();
        foreach (q[i]) if (q[i].age == m_cur) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_od();
        foreach (q[i]) if (q[i].age == m_cur) return q[i].d;
        return '0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cur = DEF;
        m_ack = 1'b0;
    endtask

    task automatic model_edge();
        bit acc;
        int req;
        acc = delay_load && (flush || (m_count() == 0 && !(en && in_valid)));
        m_ack = acc;
        if (flush || acc) begin
            q.delete();
            if (acc) begin
                req = int'(delay_sel);
                m_cur = (req < 1) ? 1 : (req > MAXD) ? MAXD : req;
            end
        end else if (en) begin
            smp_t s;
            foreach (q[i]) q[i].age++;
            while (q.size() > 0 && q[0].age > m_cur) void'(q.pop_front());
            if (in_valid) begin
                s.d = in_data;
                s.age = 1;
                q.push_back(s);
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov()));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_od()));
        chk({tag, ".count"},     32'(count),     32'(m_count()));
        chk({tag, ".cur_delay"}, 32'(cur_delay), 32'(m_cur));
        chk({tag, ".load_ack"},  32'(load_ack),  32'(m_ack));
    endtask

    task automatic drive(bit e, bit iv, logic [W-1:0] d, bit fl, bit dl, logic [CW-1:0] sel);
        en = e; in_valid = iv; in_data = d; flush = fl; delay_load = dl; delay_sel = sel;
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_model(tag);
    endtask

    typedef struct {
        bit           en, iv;
        logic [W-1:0] d;
        bit           fl, dl;
        logic [CW-1:0] sel;
        bit           eov;
        logic [W-1:0] eod;
        int           ecnt, ecur;
        bit           eack;
    } vec_t;

    function automatic vec_t mk(bit e, bit iv, int d, bit fl, bit dl, int sel,
                                bit eov, int eod, int ecnt, int ecur, bit eack);
        vec_t v;
        v.en = e; v.iv = iv; v.d = W'(d); v.fl = fl; v.dl = dl; v.sel = CW'(sel);
        v.eov = eov; v.eod = W'(eod); v.ecnt = ecnt; v.ecur = ecur; v.eack = eack;
        return v;
    endfunction

    vec_t tbl[12];

    initial begin
        tbl[0]  = mk(1, 1, 1, 0, 0, 0,  0, 0, 1, 4, 0);
        tbl[1]  = mk(1, 1, 2, 0, 0, 0,  0, 0, 2, 4, 0);
        tbl[2]  = mk(1, 1, 3, 0, 0, 0,  0, 0, 3, 4, 0);
        tbl[3]  = mk(1, 0, 0, 0, 0, 0,  1, 1, 3, 4, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0,  1, 2, 2, 4, 0);
        tbl[5]  = mk(1, 0, 0, 0, 0, 0,  1, 3, 1, 4, 0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 4, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 15, 0, 0, 0, 8, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 8, 0);
        tbl[10] = mk(0, 0, 0, 0, 1, 4,  0, 0, 0, 4, 1);
        tbl[11] = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 4, 0);

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset.out_valid", 32'(out_valid), 0);
        chk("reset.out_data", 32'(out_data), 0);
        chk("reset.count", 32'(count), 0);
        chk("reset.cur_delay", 32'(cur_delay), DEF);
        chk("reset.load_ack", 32'(load_ack), 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(tbl[i].en, tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].dl, tbl[i].sel);
            cycle(t);
            chk({t, ".tbl_ov"},   32'(out_valid), 32'(tbl[i].eov));
            chk({t, ".tbl_od"},   32'(out_data),  32'(tbl[i].eod));
            chk({t, ".tbl_cnt"},  32'(count),     32'(tbl[i].ecnt));
            chk({t, ".tbl_cur"},  32'(cur_delay), 32'(tbl[i].ecur));
            chk({t, ".tbl_ack"},  32'(load_ack),  32'(tbl[i].eack));
        end

        // Stall in the middle of the pipe stretches latency to seven edges.
        drive(1, 1, 'h2A, 0, 0, 0); cycle("stall.e1");
        drive(1, 0, 0, 0, 0, 0);    cycle("stall.e2");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 'h155, 0, 0, 0); cycle("stall.hold");
            chk("stall.count", 32'(count), 1);
            chk("stall.ov", 32'(out_valid), 0);
        end
        drive(1, 0, 0, 0, 0, 0); cycle("stall.e6");
        chk("stall.e6_ov", 32'(out_valid), 0);
        cycle("stall.e7");
        chk("stall.e7_ov", 32'(out_valid), 1);
        chk("stall.e7_od", 32'(out_data), 'h2A);
        cycle("stall.drain");
        chk("stall.drain_cnt", 32'(count), 0);

        // Reload refused while occupied, forced by flush.
        drive(1, 1, 7, 0, 0, 0); cycle("ld.f1");
        drive(1, 1, 8, 0, 0, 0); cycle("ld.f2");
        drive(1, 0, 0, 0, 1, 6); cycle("ld.refused");
        chk("ld.refused_cur", 32'(cur_delay), 4);
        chk("ld.refused_ack", 32'(load_ack), 0);
        chk("ld.refused_cnt", 32'(count), 2);
        drive(1, 0, 0, 1, 1, 6); cycle("ld.flushed");
        chk("ld.flushed_cur", 32'(cur_delay), 6);
        chk("ld.flushed_cnt", 32'(count), 0);
        chk("ld.flushed_ack", 32'(load_ack), 1);
        drive(0, 0, 0, 0, 1, 4); cycle("ld.restore");
        chk("ld.restore_cur", 32'(cur_delay), 4);

        // Flush of a full pipe drops the concurrent sample too.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, W'(20 + i), 0, 0, 0); cycle("fl.fill");
        end
        chk("fl.full_cnt", 32'(count), 4);
        drive(1, 1, 99, 1, 0, 0); cycle("fl.flush");
        chk("fl.cnt0", 32'(count), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0); cycle("fl.after");
            chk("fl.after_ov", 32'(out_valid), 0);
        end

        // Asynchronous reset with three samples in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, W'(40 + i), 0, 0, 0); cycle("rst.fill");
        end
        drive(1, 0, 0, 0, 1, 2); cycle("rst.shift");
        chk("rst.pre_cnt", 32'(count), 3);
        drive(1, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        #1;
        chk("rst.async_ov", 32'(out_valid), 0);
        chk("rst.async_od", 32'(out_data), 0);
        chk("rst.async_cnt", 32'(count), 0);
        chk("rst.async_cur", 32'(cur_delay), DEF);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1, 5, 0, 0, 0); cycle("rst.after");

        // Randomized traffic checked against the queue model every cycle.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), W'($urandom),
                  ($urandom_range(0, 40) == 0), ($urandom_range(0, 12) == 0),
                  CW'($urandom_range(0, (1 << CW) - 1)));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
